jtkcpu_stkxfer: RTL and testbench

// Stack transfer engine: the memory/register side of the PSH/PUL sequencer (jtkcpu_pshpul).

---
 rtl/jtkcpu_stkxfer_pkg.sv | 26 ++
 rtl/jtkcpu_prienc.sv | 29 ++
 rtl/jtkcpu_stkxfer_chk.sv | 15 +
 rtl/jtkcpu_stkxfer.sv | 169 ++++++++++++++++
 tb/tb_jtkcpu_stkxfer.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/jtkcpu_stkxfer_pkg.sv
// Shared definitions for the stack transfer engine: the register bit map, the
// one-hot width and the transfer-cycle kind.
package jtkcpu_stkxfer_pkg;

  localparam int PSH_W  = 8;
  localparam int PSH_CC = 0;
  localparam int PSH_A  = 1;
  localparam int PSH_B  = 2;
  localparam int PSH_DP = 3;
  localparam int PSH_X  = 4;
  localparam int PSH_Y  = 5;
  localparam int PSH_OP = 6;
  localparam int PSH_PC = 7;

  typedef enum logic [1:0] {
    XF_IDLE = 2'd0,
    XF_PUSH = 2'd1,
    XF_PULL = 2'd2
  } xfer_e;

  // Bits 4-7 of the map are the 16-bit registers.
  function automatic logic is_wide(input logic [PSH_W-1:0] sel);
    return |sel[PSH_W-1:PSH_X];
  endfunction

endpackage

// File: rtl/jtkcpu_prienc.sv
// 8-bit one-hot priority encoder; msb_first picks the highest set bit,
// otherwise the lowest. No request gives an all-zero grant.
module jtkcpu_prienc
  import jtkcpu_stkxfer_pkg::*;
(
  input  logic [PSH_W-1:0] req,
  input  logic             msb_first,
  output logic [PSH_W-1:0] grant
);

  logic [PSH_W-1:0] rev_req;
  logic [PSH_W-1:0] lsb_req;
  logic [PSH_W-1:0] lsb_rev;
  logic [PSH_W-1:0] msb_req;

  // Isolate the lowest set bit; the highest is the lowest of the reversed vector.
  always_comb begin
    rev_req = {<<{req}};
    lsb_req = req & (~req + 8'd1);
    lsb_rev = rev_req & (~rev_req + 8'd1);
    msb_req = {<<{lsb_rev}};
    if (msb_first) begin
      grant = msb_req;
    end else begin
      grant = lsb_req;
    end
  end

endmodule

// File: rtl/jtkcpu_stkxfer_chk.sv
// Protocol checker for the stack transfer engine: push and pull must never be
// requested together while a transfer is live.
module jtkcpu_stkxfer_chk (
  input logic       clk,
  input logic       rst,
  input logic       cen,
  input logic       psh_dec,
  input logic       pul_en,
  input logic [7:0] psh_sel
);

  ap_push_pull_excl: assert property (@(posedge clk) disable iff (rst)
    !(cen && psh_dec && pul_en && (|psh_sel)));

endmodule

// File: rtl/jtkcpu_stkxfer.sv
// Stack transfer engine: runs the byte bus cycles of a PSH/PUL sequence, owns
// the working stack pointer and writes the final S or U value back.
module jtkcpu_stkxfer
  import jtkcpu_stkxfer_pkg::*;
#(
  parameter int RDLAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [PSH_W-1:0] psh_sel,
  input  logic             hihalf,
  input  logic             pul_en,
  input  logic             psh_dec,
  input  logic             us_sel,
  input  logic [7:0]       cc,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  input  logic [7:0]       dp,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  input  logic [15:0]      u,
  input  logic [15:0]      s,
  input  logic [15:0]      pc,
  input  logic [7:0]       din,
  output logic [PSH_W-1:0] psh_bit,
  output logic [15:0]      addr,
  output logic [7:0]       dout,
  output logic             we,
  output logic             rd,
  output logic [PSH_W-1:0] pul_ld,
  output logic [15:0]      pul_data,
  output logic             sp_ld,
  output logic             sp_sel,
  output logic [15:0]      sp_nx,
  output logic             done
);

  if (RDLAT != 1) begin : g_rdlat_bad
    $error("jtkcpu_stkxfer: only RDLAT=1 is supported");
  end

  logic             first;
  logic [15:0]      ptr;
  logic             pipe_vld;
  logic [PSH_W-1:0] pipe_bit;
  logic             pipe_hi;
  logic             pipe_wide;
  logic [7:0]       hi_latch;

  logic             busy;
  logic             wide;
  logic             seq_end;
  logic             ret_ld;
  logic [15:0]      base;
  logic [15:0]      cur;
  logic [15:0]      word;
  xfer_e            xfer;

  jtkcpu_prienc u_prienc (
    .req       (psh_sel),
    .msb_first (~pul_en),
    .grant     (psh_bit)
  );

  jtkcpu_stkxfer_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .cen     (cen),
    .psh_dec (psh_dec),
    .pul_en  (pul_en),
    .psh_sel (psh_sel)
  );

  // Cycle classification and working pointer; pull wins over push.
  always_comb begin
    busy    = |psh_sel;
    wide    = is_wide(psh_bit);
    seq_end = !busy && !first;
    base    = us_sel ? u : s;
    cur     = first ? base : ptr;
    if (!busy) begin
      xfer = XF_IDLE;
    end else if (pul_en) begin
      xfer = XF_PULL;
    end else if (psh_dec) begin
      xfer = XF_PUSH;
    end else begin
      xfer = XF_IDLE;
    end
  end

  // Register value selected by the one-hot bit; slot 6 is the non-active pointer.
  always_comb begin
    word = 16'h0000;
    if (psh_bit[PSH_CC]) begin
      word = {8'h00, cc};
    end else if (psh_bit[PSH_A]) begin
      word = {8'h00, a};
    end else if (psh_bit[PSH_B]) begin
      word = {8'h00, b};
    end else if (psh_bit[PSH_DP]) begin
      word = {8'h00, dp};
    end else if (psh_bit[PSH_X]) begin
      word = x;
    end else if (psh_bit[PSH_Y]) begin
      word = y;
    end else if (psh_bit[PSH_OP]) begin
      word = us_sel ? s : u;
    end else if (psh_bit[PSH_PC]) begin
      word = pc;
    end else begin
      word = 16'h0000;
    end
  end

  // Bus and load outputs; strobes only fire on enabled cycles.
  always_comb begin
    addr     = (xfer == XF_PUSH) ? (cur - 16'd1) : cur;
    dout     = (wide && hihalf) ? word[15:8] : word[7:0];
    we       = cen && (xfer == XF_PUSH);
    rd       = cen && (xfer == XF_PULL);
    // The high byte of a 16-bit pull is only latched; the low byte completes the load.
    ret_ld   = pipe_vld && !(pipe_wide && !pipe_hi);
    pul_ld   = (cen && ret_ld) ? pipe_bit : 8'h00;
    pul_data = pipe_wide ? {hi_latch, din} : {8'h00, din};
    sp_ld    = cen && seq_end;
    done     = cen && seq_end;
    sp_nx    = ptr;
  end

  // Sequence state: start/end flag, pointer, pull return pipe and high-byte latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first     <= 1'b1;
      ptr       <= 16'h0000;
      sp_sel    <= 1'b0;
      pipe_vld  <= 1'b0;
      pipe_bit  <= 8'h00;
      pipe_hi   <= 1'b0;
      pipe_wide <= 1'b0;
      hi_latch  <= 8'h00;
    end else if (cen) begin
      if (first && (xfer != XF_IDLE)) begin
        first  <= 1'b0;
        sp_sel <= us_sel;
      end else if (seq_end) begin
        first <= 1'b1;
      end else begin
        first <= first;
      end
      case (xfer)
        XF_PUSH: ptr <= cur - 16'd1;
        XF_PULL: ptr <= cur + 16'd1;
        default: ptr <= ptr;
      endcase
      pipe_vld  <= (xfer == XF_PULL);
      pipe_bit  <= psh_bit;
      pipe_hi   <= hihalf;
      pipe_wide <= wide;
      if (pipe_vld && pipe_wide && !pipe_hi) begin
        hi_latch <= din;
      end else begin
        hi_latch <= hi_latch;
      end
    end
  end

endmodule

// File: tb/tb_jtkcpu_stkxfer.sv
// Directed bench for jtkcpu_stkxfer: a small sequencer model drives the byte
// sequence, a scoreboard queue holds the expected bus/load/write-back events.
module tb_jtkcpu_stkxfer;

  localparam int K_W = 0;  // write: a=addr, d=data
  localparam int K_R = 1;  // read: a=addr
  localparam int K_L = 2;  // register load: a=pul_ld, d=pul_data
  localparam int K_S = 3;  // pointer write-back: a=sp_nx, d=sp_sel

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b0;
  logic [7:0]  psh_sel = 8'h00;
  logic        hihalf = 1'b0;
  logic        pul_en = 1'b0;
  logic        psh_dec = 1'b0;
  logic        us_sel = 1'b0;
  logic [7:0]  cc = 8'h00, a = 8'h00, b = 8'h00, dp = 8'h00;
  logic [15:0] x = 16'h0000, y = 16'h0000, u = 16'h0000, s = 16'h0000, pc = 16'h0000;
  logic [7:0]  din = 8'h00;
  logic [7:0]  psh_bit, dout, pul_ld;
  logic [15:0] addr, pul_data, sp_nx;
  logic        we, rd, sp_ld, sp_sel, done;

  logic [7:0]  mem [0:65535];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;

  jtkcpu_stkxfer #(.RDLAT(1)) dut (
    .clk(clk), .rst(rst), .cen(cen), .psh_sel(psh_sel), .hihalf(hihalf),
    .pul_en(pul_en), .psh_dec(psh_dec), .us_sel(us_sel),
    .cc(cc), .a(a), .b(b), .dp(dp), .x(x), .y(y), .u(u), .s(s), .pc(pc),
    .din(din), .psh_bit(psh_bit), .addr(addr), .dout(dout), .we(we), .rd(rd),
    .pul_ld(pul_ld), .pul_data(pul_data), .sp_ld(sp_ld), .sp_sel(sp_sel),
    .sp_nx(sp_nx), .done(done)
  );

  always #5 clk = ~clk;

  // Memory with one enabled-cycle read latency (rd is already cen-qualified).
  always @(posedge clk) begin
    if (rd) din <= mem[addr];
  end

  task automatic expect_evt(input int kind, input logic [15:0] ea, input logic [15:0] ed);
    exp_t e;
    e.kind = kind; e.a = ea; e.d = ed;
    exp_q.push_back(e);
  endtask

  task automatic match(input int kind, input logic [15:0] ga, input logic [15:0] gd, input string nm);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected event a=%h d=%h", nm, ga, gd);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.a != ga || e.d != gd) begin
        errors++;
        $display("FAIL %s got kind=%0d a=%h d=%h expected kind=%0d a=%h d=%h",
                 nm, kind, ga, gd, e.kind, e.a, e.d);
      end
    end
  endtask

  // Monitor: every strobe observed mid-cycle is matched against the queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (pul_ld != 8'h00) match(K_L, {8'h00, pul_ld}, pul_data, "load");
      if (we) match(K_W, addr, {8'h00, dout}, "write");
      if (rd) match(K_R, addr, 16'h0000, "read");
      if (sp_ld) match(K_S, sp_nx, {15'd0, sp_sel}, "spld");
      if (sp_ld || done) begin
        checks++;
        if (sp_ld != done) begin
          errors++;
          $display("FAIL done_align done=%b sp_ld=%b", done, sp_ld);
        end
      end
    end
  end

  // One clock of the external sequencer: advance the byte when the cycle was enabled.
  task automatic seq_cycle(input logic c);
    logic [7:0] cur_bit;
    cen = c;
    @(posedge clk);
    #1;
    if (c && psh_sel != 8'h00) begin
      cur_bit = 8'h00;
      if (pul_en) begin
        for (int i = 7; i >= 0; i--) if (psh_sel[i]) cur_bit = 8'h01 << i;
      end else begin
        for (int i = 0; i < 8; i++) if (psh_sel[i]) cur_bit = 8'h01 << i;
      end
      if (cur_bit[7:4] != 4'h0 && !hihalf) begin
        hihalf = 1'b1;
      end else begin
        psh_sel = psh_sel & ~cur_bit;
        hihalf  = 1'b0;
      end
    end
  endtask

  task automatic drain(input string nm);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing %0d expected events", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_seq(input logic [7:0] mask, input logic pull, input logic us,
                         input logic toggle, input logic [7:0] first_bit, input string nm);
    int n;
    psh_sel = mask; pul_en = pull; psh_dec = !pull; us_sel = us; hihalf = 1'b0;
    #1;
    checks++;
    if (psh_bit != first_bit) begin
      errors++;
      $display("FAIL %s_first_bit got %h expected %h", nm, psh_bit, first_bit);
    end
    n = 0;
    while (psh_sel != 8'h00 && n < 200) begin
      seq_cycle(toggle ? (n % 2 == 0) : 1'b1);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      if (toggle) seq_cycle(1'b0);
      seq_cycle(1'b1);
    end
    pul_en = 1'b0; psh_dec = 1'b0;
    seq_cycle(1'b1);
    drain(nm);
  endtask

  initial begin
    logic [7:0] t3_bytes [12];
    mem[16'h2000] = 8'hAA; mem[16'h2001] = 8'h12; mem[16'h2002] = 8'h34;
    mem[16'h4000] = 8'h5A; mem[16'h4001] = 8'hC3; mem[16'h4002] = 8'h3C;
    mem[16'h5000] = 8'h77; mem[16'h5001] = 8'h88;

    // Reset state
    cen = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({we, rd, pul_ld, sp_ld, done, psh_bit} != 20'h00000) begin
      errors++;
      $display("FAIL reset_strobes got %h expected 00000", {we, rd, pul_ld, sp_ld, done, psh_bit});
    end
    checks++;
    if (sp_nx != 16'h0000) begin
      errors++;
      $display("FAIL reset_ptr got %h expected 0000", sp_nx);
    end
    @(posedge clk); #1;

    // 1: push PC,A from S=1000
    s = 16'h1000; u = 16'h3000; pc = 16'h1234; a = 8'h56;
    expect_evt(K_W, 16'h0FFF, 16'h0034);
    expect_evt(K_W, 16'h0FFE, 16'h0012);
    expect_evt(K_W, 16'h0FFD, 16'h0056);
    expect_evt(K_S, 16'h0FFD, 16'h0000);
    run_seq(8'h82, 1'b0, 1'b0, 1'b0, 8'h80, "push_pc_a");

    // 2: pull CC,X from U=2000
    u = 16'h2000;
    expect_evt(K_R, 16'h2000, 16'h0000);
    expect_evt(K_L, 16'h0001, 16'h00AA);
    expect_evt(K_R, 16'h2001, 16'h0000);
    expect_evt(K_R, 16'h2002, 16'h0000);
    expect_evt(K_L, 16'h0010, 16'h1234);
    expect_evt(K_S, 16'h2003, 16'h0001);
    run_seq(8'h11, 1'b1, 1'b1, 1'b0, 8'h01, "pull_cc_x");

    // 3: push all from S=0003 with wrap
    s = 16'h0003; u = 16'hBEEF; pc = 16'h99AA; y = 16'h7788; x = 16'h5566;
    dp = 8'h44; b = 8'h33; a = 8'h22; cc = 8'h11;
    t3_bytes = '{8'hAA, 8'h99, 8'hEF, 8'hBE, 8'h88, 8'h77, 8'h66, 8'h55,
                 8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 12; i++) begin
      expect_evt(K_W, 16'h0002 - 16'(i), {8'h00, t3_bytes[i]});
    end
    expect_evt(K_S, 16'hFFF7, 16'h0000);
    run_seq(8'hFF, 1'b0, 1'b0, 1'b0, 8'h80, "push_all");

    // 4: pull A,Y from S=4000 with cen toggling
    s = 16'h4000;
    expect_evt(K_R, 16'h4000, 16'h0000);
    expect_evt(K_L, 16'h0002, 16'h005A);
    expect_evt(K_R, 16'h4001, 16'h0000);
    expect_evt(K_R, 16'h4002, 16'h0000);
    expect_evt(K_L, 16'h0020, 16'hC33C);
    expect_evt(K_S, 16'h4003, 16'h0000);
    run_seq(8'h22, 1'b1, 1'b0, 1'b1, 8'h02, "pull_cen_toggle");

    // 5: reset after first byte of a 16-bit pull, then restart from base
    s = 16'h5000;
    psh_sel = 8'h10; pul_en = 1'b1; psh_dec = 1'b0; us_sel = 1'b0; hihalf = 1'b0;
    expect_evt(K_R, 16'h5000, 16'h0000);
    seq_cycle(1'b1);
    rst = 1'b1; psh_sel = 8'h00; pul_en = 1'b0; hihalf = 1'b0;
    repeat (2) seq_cycle(1'b1);
    rst = 1'b0;
    repeat (4) seq_cycle(1'b1);
    drain("reset_abort");
    expect_evt(K_R, 16'h5000, 16'h0000);
    expect_evt(K_L, 16'h0002, 16'h0077);
    expect_evt(K_S, 16'h5001, 16'h0000);
    run_seq(8'h02, 1'b1, 1'b0, 1'b0, 8'h02, "restart_base");

    // 6: empty postbyte
    psh_sel = 8'h00; pul_en = 1'b1;
    repeat (4) seq_cycle(1'b1);
    pul_en = 1'b0;
    seq_cycle(1'b1);
    drain("empty_mask");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
